// File: rtl/hazard_fwd_if.sv
// Signal bundle between the pipeline control path and the hazard/forwarding unit.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface hazard_fwd_if #(
    parameter int CNT_W = 16
);
    logic             L_EX;
    logic             RF_LE_EX;
    logic [4:0]       RD_EX;
    logic             RF_LE_MEM;
    logic [4:0]       RD_MEM;
    logic             RF_LE_WB;
    logic [4:0]       RD_WB;
    logic [4:0]       RA_ID;
    logic [4:0]       RB_ID;
    logic [4:0]       RC_ID;
    logic             CC_WE_EX;
    logic             USE_CC_ID;
    logic             kill_D;
    logic             cnt_clr;

    logic             stall_F;
    logic             stall_D;
    logic             flush_E;
    logic [1:0]       fwd_A;
    logic [1:0]       fwd_B;
    logic [1:0]       fwd_C;
    logic             cc_fwd;
    logic             ld_wait;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output L_EX, RF_LE_EX, RD_EX, RF_LE_MEM, RD_MEM, RF_LE_WB, RD_WB,
               RA_ID, RB_ID, RC_ID, CC_WE_EX, USE_CC_ID, kill_D, cnt_clr,
        input  stall_F, stall_D, flush_E, fwd_A, fwd_B, fwd_C, cc_fwd,
               ld_wait, stall_cnt
    );

    modport slave (
        input  L_EX, RF_LE_EX, RD_EX, RF_LE_MEM, RD_MEM, RF_LE_WB, RD_WB,
               RA_ID, RB_ID, RC_ID, CC_WE_EX, USE_CC_ID, kill_D, cnt_clr,
        output stall_F, stall_D, flush_E, fwd_A, fwd_B, fwd_C, cc_fwd,
               ld_wait, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard unit for the 5-stage pipeline: multi-cycle load-use stall FSM, CC hazard
// stall-or-forward, ID operand forwarding selects and a saturating stall counter.
module hazard_fwd_unit #(
    parameter int LOAD_LAT = 1,
    parameter int CC_FWD   = 0,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_fwd_if.slave    bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu;
    logic cch;
    logic stall;
    logic cc_fwd_o;

    // Forward source priority: youngest producer wins; a load in EX has no data yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       ex_ok,
        input logic [4:0] rd_ex,
        input logic       mem_ok,
        input logic [4:0] rd_mem,
        input logic       wb_ok,
        input logic [4:0] rd_wb
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (ex_ok && (rd_ex == r))        sel = 2'd1;
            else if (mem_ok && (rd_mem == r)) sel = 2'd2;
            else if (wb_ok && (rd_wb == r))   sel = 2'd3;
        end
        return sel;
    endfunction

    assign lu = bus.L_EX && bus.RF_LE_EX && (bus.RD_EX != 5'd0) &&
                ((bus.RD_EX == bus.RA_ID) || (bus.RD_EX == bus.RB_ID) ||
                 (bus.RD_EX == bus.RC_ID));

    assign cch = bus.CC_WE_EX && bus.USE_CC_ID;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        stall    = 1'b0;
        cc_fwd_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (lu && !bus.kill_D) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LD_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end
                end else if (cch && (CC_FWD == 0) && !bus.kill_D) begin
                    stall = 1'b1;
                end else if (cch && (CC_FWD != 0)) begin
                    cc_fwd_o = 1'b1;
                end
            end
            LD_WAIT: begin
                // A taken branch annuls the stalled instruction, so the wait is abandoned.
                if (bus.kill_D) begin
                    state_d = IDLE;
                    wcnt_d  = 3'd0;
                end else begin
                    stall  = 1'b1;
                    wcnt_d = wcnt_q - 3'd1;
                    if (wcnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_F   = stall;
    assign bus.stall_D   = stall;
    assign bus.flush_E   = stall;
    assign bus.cc_fwd    = cc_fwd_o;
    assign bus.ld_wait   = (state_q == LD_WAIT);
    assign bus.stall_cnt = cnt_q;

    assign bus.fwd_A = fwd_sel(bus.RA_ID, bus.RF_LE_EX && !bus.L_EX, bus.RD_EX,
                               bus.RF_LE_MEM, bus.RD_MEM, bus.RF_LE_WB, bus.RD_WB);
    assign bus.fwd_B = fwd_sel(bus.RB_ID, bus.RF_LE_EX && !bus.L_EX, bus.RD_EX,
                               bus.RF_LE_MEM, bus.RD_MEM, bus.RF_LE_WB, bus.RD_WB);
    assign bus.fwd_C = fwd_sel(bus.RC_ID, bus.RF_LE_EX && !bus.L_EX, bus.RD_EX,
                               bus.RF_LE_MEM, bus.RD_MEM, bus.RF_LE_WB, bus.RD_WB);
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: three configurations share one stimulus stream; each check names
// the instance it targets (0: LOAD_LAT=1, 1: LOAD_LAT=3/CNT_W=4, 2: CC_FWD=1).
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst_n;

    logic       L_EX, RF_LE_EX, RF_LE_MEM, RF_LE_WB;
    logic [4:0] RD_EX, RD_MEM, RD_WB, RA_ID, RB_ID, RC_ID;
    logic       CC_WE_EX, USE_CC_ID, kill_D, cnt_clr;

    // {stall_F, stall_D, flush_E, fwd_A, fwd_B, fwd_C, cc_fwd, ld_wait, stall_cnt[15:0]}
    logic [26:0] act [3];

    typedef struct {
        int          tag;
        string       name;
        logic [26:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LL = (g == 1) ? 3 : 1;
        localparam int CF = (g == 2) ? 1 : 0;
        localparam int CW = (g == 1) ? 4 : 16;

        hazard_fwd_if #(.CNT_W(CW)) bus ();

        assign bus.L_EX      = L_EX;
        assign bus.RF_LE_EX  = RF_LE_EX;
        assign bus.RD_EX     = RD_EX;
        assign bus.RF_LE_MEM = RF_LE_MEM;
        assign bus.RD_MEM    = RD_MEM;
        assign bus.RF_LE_WB  = RF_LE_WB;
        assign bus.RD_WB     = RD_WB;
        assign bus.RA_ID     = RA_ID;
        assign bus.RB_ID     = RB_ID;
        assign bus.RC_ID     = RC_ID;
        assign bus.CC_WE_EX  = CC_WE_EX;
        assign bus.USE_CC_ID = USE_CC_ID;
        assign bus.kill_D    = kill_D;
        assign bus.cnt_clr   = cnt_clr;

        hazard_fwd_unit #(.LOAD_LAT(LL), .CC_FWD(CF), .CNT_W(CW)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign act[g] = {bus.stall_F, bus.stall_D, bus.flush_E, bus.fwd_A, bus.fwd_B,
                         bus.fwd_C, bus.cc_fwd, bus.ld_wait, 16'(bus.stall_cnt)};
    end

    function automatic string fmt(input logic [26:0] v);
        return $sformatf("stall=%b fwdA=%0d fwdB=%0d fwdC=%0d ccf=%b ldw=%b cnt=%0d",
                         v[26:24], v[23:22], v[21:20], v[19:18], v[17], v[16], v[15:0]);
    endfunction

    // Monitor: every pending expectation is compared on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (act[e.tag] !== e.v) begin
                n_fail++;
                $display("FAIL %s (dut%0d): actual %s, required %s",
                         e.name, e.tag, fmt(act[e.tag]), fmt(e.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        L_EX = 0; RF_LE_EX = 0; RD_EX = 0; RF_LE_MEM = 0; RD_MEM = 0;
        RF_LE_WB = 0; RD_WB = 0; RA_ID = 0; RB_ID = 0; RC_ID = 0;
        CC_WE_EX = 0; USE_CC_ID = 0; kill_D = 0; cnt_clr = 0;
    endtask

    task automatic rst_all();
        clr();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rc);
        L_EX = 1; RF_LE_EX = 1; RD_EX = rd; RC_ID = rc;
    endtask

    task automatic chk(input int tag, input string nm, input logic s,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fc,
                       input logic ccf, input logic ldw, input logic [15:0] cnt);
        exp_t e;
        e.tag  = tag;
        e.name = nm;
        e.v    = {{3{s}}, fa, fb, fc, ccf, ldw, cnt};
        sb.push_back(e);
    endtask

    initial begin
        clr();
        rst_n = 0;
        tick();
        chk(0, "reset_u1", 0, 0, 0, 0, 0, 0, 0);
        chk(1, "reset_u3", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        tick();

        // Load-use with one cycle of latency
        rst_all();
        L_EX = 1; RF_LE_EX = 1; RD_EX = 5; RA_ID = 5;
        chk(0, "ll1_stall", 1, 0, 0, 0, 0, 0, 0);
        tick();
        clr();
        chk(0, "ll1_release", 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Load-use with three cycles of latency on the store-data register
        rst_all();
        load_use(5, 5);
        chk(1, "ll3_c1", 1, 0, 0, 0, 0, 0, 0);
        tick();
        clr();
        chk(1, "ll3_c2", 1, 0, 0, 0, 0, 1, 1);
        tick();
        chk(1, "ll3_c3", 1, 0, 0, 0, 0, 1, 2);
        tick();
        chk(1, "ll3_idle", 0, 0, 0, 0, 0, 0, 3);
        tick();

        // Branch kill on the second stall cycle
        rst_all();
        load_use(5, 5);
        chk(1, "kill_c1", 1, 0, 0, 0, 0, 0, 0);
        tick();
        clr();
        kill_D = 1;
        chk(1, "kill_c2", 0, 0, 0, 0, 0, 1, 1);
        tick();
        kill_D = 0;
        chk(1, "kill_idle", 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Condition-code hazard: stall variant vs forward variant
        rst_all();
        CC_WE_EX = 1; USE_CC_ID = 1;
        chk(0, "cc_stall", 1, 0, 0, 0, 0, 0, 0);
        chk(2, "cc_fwd", 0, 0, 0, 0, 1, 0, 0);
        tick();
        clr();
        chk(0, "cc_stall_cnt", 0, 0, 0, 0, 0, 0, 1);
        chk(2, "cc_fwd_cnt", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Operand forwarding priority
        rst_all();
        RA_ID = 7; RB_ID = 7; RC_ID = 3;
        RD_EX = 7; RF_LE_EX = 1; RD_MEM = 7; RF_LE_MEM = 1; RD_WB = 7; RF_LE_WB = 1;
        chk(0, "fwd_ex", 0, 1, 1, 0, 0, 0, 0);
        tick();
        RF_LE_EX = 0;
        chk(0, "fwd_mem", 0, 2, 2, 0, 0, 0, 0);
        tick();
        RA_ID = 0;
        chk(0, "fwd_r0", 0, 0, 2, 0, 0, 0, 0);
        tick();
        RF_LE_MEM = 0; RC_ID = 7;
        chk(0, "fwd_wb", 0, 0, 3, 3, 0, 0, 0);
        tick();
        L_EX = 1; RF_LE_EX = 1; RC_ID = 3;
        chk(0, "fwd_no_load", 1, 0, 3, 0, 0, 0, 0);
        tick();
        clr();
        L_EX = 1; RF_LE_EX = 1; RD_EX = 0;
        chk(0, "lu_rd0", 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Counter saturation and clear on the 4-bit instance
        rst_all();
        CC_WE_EX = 1; USE_CC_ID = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 14) chk(1, "cnt_14", 1, 0, 0, 0, 0, 0, 14);
            tick();
        end
        cnt_clr = 1;
        chk(1, "cnt_sat", 1, 0, 0, 0, 0, 0, 15);
        tick();
        clr();
        chk(1, "cnt_clr", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset in the middle of a load wait
        rst_all();
        load_use(5, 5);
        chk(1, "rstw_c1", 1, 0, 0, 0, 0, 0, 0);
        tick();
        clr();
        rst_n = 0;
        chk(1, "rstw_c2", 1, 0, 0, 0, 0, 1, 1);
        tick();
        rst_n = 1;
        chk(1, "rstw_idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Next-generation hazard unit for the 5-stage pipeline. It detects load-use hazards with a configurable load latency and stalls for multiple cycles using a wait-state FSM. It resolves condition-code hazards either by stalling or by forwarding, selected at elaboration time, and produces the operand-forwarding mux selects for ID. It also keeps a saturating stall-cycle performance counter. It sits beside the ID stage and drives PC/nPC enable, the IF/ID enable, the ID/EX bubble, and the EX-operand forwarding muxes.

Parameters:
LOAD_LAT, 1, total stall cycles per load-use hazard (legal 1..7).
CC_FWD, 0, 0 = stall one cycle on CC hazard; 1 = forward CC from EX, no stall.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
L_EX  in  1  instruction in EX is a LOAD
RF_LE_EX  in  1  EX instruction writes RF
RD_EX  in  5  EX destination
RF_LE_MEM  in  1  MEM instruction writes RF
RD_MEM  in  5  MEM destination
RF_LE_WB  in  1  WB instruction writes RF
RD_WB  in  5  WB destination
RA_ID  in  5  rs1 in ID
RB_ID  in  5  rs2 in ID
RC_ID  in  5  store-data register in ID
CC_WE_EX  in  1  EX instruction writes CC
USE_CC_ID  in  1  ID instruction is a conditional branch
kill_D  in  1  taken branch annuls the ID instruction this cycle
cnt_clr  in  1  clear stall counter
stall_F  out  1  hold PC/nPC
stall_D  out  1  hold IF/ID
flush_E  out  1  insert bubble into ID/EX
fwd_A  out  2  rs1 select: 0=RF, 1=EX, 2=MEM, 3=WB
fwd_B  out  2  rs2 select, same encoding
fwd_C  out  2  store-data select, same encoding
cc_fwd  out  1  branch uses CC from EX ALU (CC_FWD=1 only)
ld_wait  out  1  FSM is in LD_WAIT
stall_cnt  out  CNT_W  saturating count of cycles with stall_F=1

Behaviour:
- Reset: when rst_n=0 at a clock edge, the FSM goes to IDLE, the wait counter goes to 0 and stall_cnt goes to 0. Combinational outputs follow from IDLE with the current inputs.
- Hazard detection (combinational):
  - lu = L_EX & RF_LE_EX & RD_EX!=0 & RD_EX ∈ {RA_ID, RB_ID, RC_ID}.
  - cch = CC_WE_EX & USE_CC_ID.
- FSM states are IDLE and LD_WAIT, with a 3-bit remaining-cycle counter wcnt.
- IDLE:
  - If lu & !kill_D: stall_F = stall_D = flush_E = 1 this cycle. If LOAD_LAT>1, go to LD_WAIT with wcnt = LOAD_LAT-1. Otherwise stay in IDLE.
  - Else if cch & CC_FWD=0 & !kill_D: 1-cycle stall with the same three outputs, stay in IDLE.
  - Else if cch & CC_FWD=1: cc_fwd=1, no stall.
- LD_WAIT:
  - stall_F = stall_D = flush_E = 1 and ld_wait = 1.
  - wcnt decrements each cycle. Leave for IDLE on the cycle in which wcnt==1 (the last stall cycle).
  - Net effect: exactly LOAD_LAT consecutive stall cycles per load-use hazard.
  - A new detection is not evaluated while in LD_WAIT, because the EX stage holds bubbles.
- kill_D has priority over every stall:
  - In IDLE it suppresses stalls that same cycle.
  - In LD_WAIT it forces stall outputs to 0 that cycle and the next state to IDLE.
- Forwarding (combinational, per source R ∈ {RA_ID, RB_ID, RC_ID}):
  - R==0 → select 0.
  - Else, first match in this priority order:
    - EX: RF_LE_EX & !L_EX & RD_EX==R → 1.
    - MEM: RF_LE_MEM & RD_MEM==R → 2.
    - WB: RF_LE_WB & RD_WB==R → 3.
    - No match → 0.
  - A load in EX is never a forward source.
- cc_fwd is held at 0 when CC_FWD=0.
- stall_cnt increments on every edge where stall_F=1 and saturates at all-ones. cnt_clr=1 zeroes it and has priority over increment. Reset has priority over both.
- Reset asserted mid-LD_WAIT: return to IDLE on that edge; no stall is carried over.

Test Plan:
- LOAD_LAT=1, L_EX=1, RF_LE_EX=1, RD_EX=5, RA_ID=5 → stall_F/stall_D/flush_E=1 for exactly 1 cycle, ld_wait stays 0, stall_cnt=1.
- LOAD_LAT=3, same load-use on RC_ID=5 → 3 consecutive stall cycles, ld_wait=1 on cycles 2–3, then IDLE, stall_cnt=3.
- LOAD_LAT=3, kill_D=1 on the 2nd stall cycle → stall_F=0 that cycle, next state IDLE, stall_cnt=1.
- CC_WE_EX=1, USE_CC_ID=1: with CC_FWD=0 → one stall cycle, cc_fwd=0; with CC_FWD=1 → no stall, cc_fwd=1.
- RA_ID=7 with RD_EX=7 (non-load), RD_MEM=7 and RD_WB=7 all writing → fwd_A=1. Set RF_LE_EX=0 → fwd_A=2. Set RA_ID=0 → fwd_A=0.
- CNT_W=4: run 20 stall cycles → stall_cnt=15 (saturated). cnt_clr=1 → stall_cnt=0. rst_n=0 mid-LD_WAIT → IDLE, all stall outputs 0 on the next cycle.
